// File: rtl/lc3b_types.sv
// Shared LC-3b bus types used by the memory responder and its array.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int LC3B_CNT_W = 4;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word-addressed 16-bit storage: byte-masked synchronous write, combinational read.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  lc3b_mem_wmask        wmask,
  input  logic [ADDR_BITS-1:0] addr,
  input  lc3b_word             wdata,
  output lc3b_word             rdata
);

  lc3b_word mem [2**ADDR_BITS];

  // Contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[addr][7:0]  <= wdata[7:0];
      if (wmask[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency memory model answering LC-3b CPU read/write requests.
//   state | meaning
//   IDLE  | waiting for exactly one of mem_read / mem_write
//   BUSY  | latency countdown on the captured request
//   DONE  | mem_resp pulse; write lands on the edge leaving this state
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          proto_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [LC3B_CNT_W-1:0] CNT_LOAD = LC3B_CNT_W'(LATENCY - 1);

  state_t                  state, next_state;
  logic [LC3B_CNT_W-1:0]   cnt;
  logic                    op_write;
  logic [ADDR_BITS-1:0]    idx_q;
  lc3b_word                wdata_q;
  lc3b_mem_wmask           mask_q;
  lc3b_word                rdata_q;
  logic                    proto_err_q;

  logic                    req_one, req_any, req_both;
  logic                    arr_we, load_rdata, rd_op;
  logic [ADDR_BITS-1:0]    arr_addr;
  lc3b_word                arr_rdata;
  logic                    unused_addr;

  assign req_one     = mem_read ^ mem_write;
  assign req_any     = mem_read | mem_write;
  assign req_both    = mem_read & mem_write;
  assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (req_one) next_state = (LATENCY == 1) ? DONE : BUSY;
      BUSY: begin
        if (!req_any)      next_state = IDLE;
        else if (cnt <= 1) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_resp   = (state == DONE);
    rd_op      = (state == IDLE) ? mem_read : !op_write;
    load_rdata = (state != DONE) && (next_state == DONE) && rd_op;
    arr_we     = (state == DONE) && op_write && rst_n;
    // In IDLE the array is addressed straight from the bus so LATENCY=1 reads work.
    arr_addr   = (state == IDLE) ? mem_address[ADDR_BITS:1] : idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_write    <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (state == IDLE && req_both) proto_err_q <= 1'b1;
      if (load_rdata) rdata_q <= arr_rdata;
      unique case (state)
        IDLE: if (req_one) begin
          cnt      <= CNT_LOAD;
          op_write <= mem_write;
          idx_q    <= mem_address[ADDR_BITS:1];
          wdata_q  <= mem_wdata;
          mask_q   <= mem_byte_enable;
        end
        BUSY:    cnt <= req_any ? cnt - 1'b1 : '0;
        default: cnt <= '0;
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign proto_err = proto_err_q;

  lc3b_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .wmask (mask_q),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomized check of two responder instances (LATENCY 3 and 1) against a word-array model.
module tb_lc3b_mem_responder;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n           [2];
  logic          mem_read        [2];
  logic          mem_write       [2];
  lc3b_word      mem_address     [2];
  lc3b_word      mem_wdata       [2];
  lc3b_mem_wmask mem_byte_enable [2];
  logic          mem_resp        [2];
  lc3b_word      mem_rdata       [2];
  logic          proto_err       [2];

  int       checks = 0;
  int       errors = 0;
  int       lat [2] = '{3, 1};
  lc3b_word model [2][256];
  lc3b_word last_rd [2];

  always #5 clk = ~clk;

  lc3b_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) dut_l3 (
    .clk(clk), .rst_n(rst_n[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_byte_enable(mem_byte_enable[0]),
    .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]), .proto_err(proto_err[0])
  );

  lc3b_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut_l1 (
    .clk(clk), .rst_n(rst_n[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_byte_enable(mem_byte_enable[1]),
    .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]), .proto_err(proto_err[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle, wait for the pulse, then spend one idle cycle.
  task automatic do_op(input int d, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [1:0] mask, input bit scramble, input string tag);
    int       seen;
    lc3b_word rd;
    lc3b_word old;
    int       idx;
    seen = 0;
    rd   = '0;
    mem_address[d]     = addr;
    mem_wdata[d]       = wd;
    mem_byte_enable[d] = mask;
    mem_read[d]        = !wr;
    mem_write[d]       = wr;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      step();
      if (mem_resp[d]) begin
        seen = k;
        rd   = mem_rdata[d];
      end else if (scramble) begin
        mem_address[d]     = 16'($urandom);
        mem_wdata[d]       = 16'($urandom);
        mem_byte_enable[d] = 2'($urandom);
      end
    end
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    check_val({tag, " latency"}, seen, lat[d]);
    idx = int'(addr[8:1]);
    if (wr) begin
      old = model[d][idx];
      model[d][idx] = {mask[1] ? wd[15:8] : old[15:8], mask[0] ? wd[7:0] : old[7:0]};
    end else begin
      check_val({tag, " rdata"}, rd, model[d][idx]);
      last_rd[d] = model[d][idx];
    end
    step();
    check_val({tag, " resp_off"}, mem_resp[d], 1'b0);
    check_val({tag, " rdata_hold"}, mem_rdata[d], last_rd[d]);
  endtask

  // Start a request, drop it after n cycles while still counting; nothing may respond or commit.
  task automatic do_abort(input int d, input bit wr, input logic [15:0] addr, input int n);
    mem_address[d]     = addr;
    mem_wdata[d]       = 16'($urandom);
    mem_byte_enable[d] = 2'b11;
    mem_read[d]        = !wr;
    mem_write[d]       = wr;
    for (int k = 1; k <= n; k++) begin
      step();
      check_val("abort busy resp", mem_resp[d], 1'b0);
    end
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    step();
    check_val("abort idle resp", mem_resp[d], 1'b0);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    step();
    check_val("reset resp", mem_resp[d], 1'b0);
    check_val("reset rdata", mem_rdata[d], 16'h0000);
    check_val("reset proto_err", proto_err[d], 1'b0);
    rst_n[d] = 1'b1;
    last_rd[d] = '0;
  endtask

  task automatic random_ops(input int d, input int count);
    logic [15:0] a;
    int          sel;
    for (int i = 0; i < count; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[8:5] = 4'h0;
      sel = int'($urandom_range(0, 7));
      if (sel == 0 && lat[d] > 1)
        do_abort(d, $urandom_range(0, 1) == 1, a, int'($urandom_range(1, lat[d] - 1)));
      else
        do_op(d, $urandom_range(0, 1) == 1, a, 16'($urandom), 2'($urandom),
              $urandom_range(0, 1) == 1, "random");
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      mem_address[d] = '0; mem_wdata[d] = '0; mem_byte_enable[d] = '0;
      last_rd[d] = '0;
    end
    step();
    step();
    for (int d = 0; d < 2; d++) do_reset(d);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) do_op(d, 1'b1, 16'(i * 2), 16'h0000, 2'b11, 1'b0, "init");

    do_op(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, "beef write");
    do_op(0, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, "beef read");
    check_val("beef value", mem_rdata[0], 16'hBEEF);

    do_op(0, 1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, "lane full");
    do_op(0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 1'b0, "lane hi");
    do_op(0, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, "lane read1");
    check_val("lane value1", mem_rdata[0], 16'hAB34);
    do_op(0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 1'b0, "lane none");
    do_op(0, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, "lane read2");
    check_val("lane value2", mem_rdata[0], 16'hAB34);

    do_abort(0, 1'b0, 16'h0010, 1);
    do_op(0, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, "after abort");

    check_val("proto before", proto_err[0], 1'b0);
    mem_read[0] = 1'b1; mem_write[0] = 1'b1; mem_address[0] = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("proto resp", mem_resp[0], 1'b0);
      check_val("proto set", proto_err[0], 1'b1);
    end
    mem_read[0] = 1'b0; mem_write[0] = 1'b0;
    step();
    check_val("proto sticky", proto_err[0], 1'b1);
    do_op(0, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, "proto then read");
    check_val("proto still", proto_err[0], 1'b1);

    do_op(0, 1'b1, 16'h0030, 16'h0000, 2'b11, 1'b0, "rst prior");
    mem_address[0] = 16'h0030; mem_wdata[0] = 16'h5555; mem_byte_enable[0] = 2'b11;
    mem_write[0] = 1'b1;
    step();
    do_reset(0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("rst no resp", mem_resp[0], 1'b0);
    end
    do_op(0, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0, "rst readback");
    check_val("rst value", mem_rdata[0], 16'h0000);

    random_ops(0, 150);

    do_op(1, 1'b1, 16'h0000, 16'h1357, 2'b11, 1'b0, "l1 w0");
    do_op(1, 1'b1, 16'h0002, 16'h2468, 2'b11, 1'b0, "l1 w2");
    do_op(1, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, "l1 r0");
    do_op(1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0, "l1 r2");
    step();
    check_val("l1 hold", mem_rdata[1], 16'h2468);
    check_val("l1 alias", model[1][1], 16'h2468);
    do_op(1, 1'b0, 16'hFE00, 16'h0000, 2'b00, 1'b0, "l1 alias read");
    check_val("l1 alias value", mem_rdata[1], 16'h1357);

    random_ops(1, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
